score_keeper: RTL and testbench

Parametrised, clocked score-keeping block for the whack-a-mole game. It edge-detects hit and miss events from game logic and keeps a saturating score. It adds a streak bonus for consecutive hits, subtracts a penalty for misses, and tracks a high score that survives game restarts. It sits between the mole/hit-detection logic and the score display driver.

---
 rtl/score_keeper.sv | 62 ++++++
 tb/tb_score_keeper.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// score_keeper: saturating whack-a-mole score with streak bonus, miss penalty and persistent high score
//   clk, reset (sync, active-high), enable, restart, whacked, missed  -> inputs
//   score, high_score, streak, new_high, bonus, sat                   -> outputs
module score_keeper #(
  parameter int SCORE_W      = 16,
  parameter int STREAK_W     = 8,
  parameter int HIT_POINTS   = 1,
  parameter int MISS_PENALTY = 1,
  parameter int STREAK_LEN   = 4,
  parameter int BONUS_POINTS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                restart,
  input  logic                whacked,
  input  logic                missed,
  output logic [SCORE_W-1:0]  score,
  output logic [SCORE_W-1:0]  high_score,
  output logic [STREAK_W-1:0] streak,
  output logic                new_high,
  output logic                bonus,
  output logic                sat
);
  // Divisor kept nonzero so the modulo stays legal when the bonus is disabled
  localparam int SL = (STREAK_LEN == 0) ? 1 : STREAK_LEN;
  logic                prev_w, prev_m, hit_ev, miss_ev, bonus_hit;
  logic [STREAK_W-1:0] streak_inc, streak_n;
  logic [SCORE_W:0]    sum;
  logic [SCORE_W-1:0]  score_add, score_sub, score_n;
  always_comb begin
    hit_ev     = whacked & ~prev_w & enable;
    miss_ev    = missed & ~prev_m & enable;
    streak_inc = (streak == '1) ? streak : streak + STREAK_W'(1);
    bonus_hit  = (STREAK_LEN != 0) && (streak_inc % STREAK_W'(SL) == '0);
    sum        = {1'b0, score} + (SCORE_W+1)'(bonus_hit ? HIT_POINTS + BONUS_POINTS : HIT_POINTS);
    score_add  = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    score_sub  = (score < SCORE_W'(MISS_PENALTY)) ? '0 : score - SCORE_W'(MISS_PENALTY);
    score_n    = miss_ev ? score_sub : hit_ev ? score_add : score;
    streak_n   = miss_ev ? '0 : hit_ev ? streak_inc : streak;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_w     <= 1'b0;
      prev_m     <= 1'b0;
      score      <= '0;
      high_score <= '0;
      streak     <= '0;
      new_high   <= 1'b0;
      bonus      <= 1'b0;
    end else begin
      prev_w   <= whacked;
      prev_m   <= missed;
      score    <= restart ? '0 : score_n;
      streak   <= restart ? '0 : streak_n;
      bonus    <= ~restart & hit_ev & ~miss_ev & bonus_hit;
      new_high <= ~restart & (score_n > high_score);
      if (!restart && score_n > high_score) high_score <= score_n;
    end
  end
  assign sat = (score == '1);
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: table, directed and random checks of score_keeper against a behavioural model
module tb_score_keeper;
  logic clk = 0, reset = 1, enable = 0, restart = 0, whacked = 0, missed = 0;
  logic [15:0] score_a, high_a;
  logic [7:0]  streak_a;
  logic        new_high_a, bonus_a, sat_a;
  logic [3:0]  score_b, high_b;
  logic [2:0]  streak_b;
  logic        new_high_b, bonus_b, sat_b;
  int total = 0, bad = 0;
  always #5 clk = ~clk;

  score_keeper dut_a (
    .clk(clk), .reset(reset), .enable(enable), .restart(restart), .whacked(whacked), .missed(missed),
    .score(score_a), .high_score(high_a), .streak(streak_a), .new_high(new_high_a), .bonus(bonus_a), .sat(sat_a)
  );
  score_keeper #(.SCORE_W(4), .STREAK_W(3)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .restart(restart), .whacked(whacked), .missed(missed),
    .score(score_b), .high_score(high_b), .streak(streak_b), .new_high(new_high_b), .bonus(bonus_b), .sat(sat_b)
  );

  // Reference model: index 0 = default parameters, index 1 = 4-bit score / 3-bit streak
  localparam int SMAX[2] = '{65535, 15};
  localparam int KMAX[2] = '{255, 7};
  int ms[2], mh[2], mk[2];
  bit mb[2], mn[2];
  bit mpw, mpm;

  task automatic model(input bit r, rs, en, w, m);
    bit hit, miss;
    hit  = w && !mpw && en;
    miss = m && !mpm && en;
    mpw  = r ? 1'b0 : w;
    mpm  = r ? 1'b0 : m;
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        ms[k] = 0; mh[k] = 0; mk[k] = 0; mb[k] = 0; mn[k] = 0;
      end else if (rs) begin
        ms[k] = 0; mk[k] = 0; mb[k] = 0; mn[k] = 0;
      end else begin
        mb[k] = 0;
        if (miss) begin
          mk[k] = 0;
          ms[k] = (ms[k] >= 1) ? ms[k] - 1 : 0;
        end else if (hit) begin
          mk[k] = (mk[k] + 1 > KMAX[k]) ? KMAX[k] : mk[k] + 1;
          mb[k] = (mk[k] % 4 == 0);
          ms[k] = ms[k] + 1 + (mb[k] ? 2 : 0);
          if (ms[k] > SMAX[k]) ms[k] = SMAX[k];
        end
        mn[k] = ms[k] > mh[k];
        if (mn[k]) mh[k] = ms[k];
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    total++;
    if (act !== 32'(exp)) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("score_a", 32'(score_a), ms[0]);
    chk("high_a", 32'(high_a), mh[0]);
    chk("streak_a", 32'(streak_a), mk[0]);
    chk("bonus_a", 32'(bonus_a), int'(mb[0]));
    chk("new_high_a", 32'(new_high_a), int'(mn[0]));
    chk("sat_a", 32'(sat_a), int'(ms[0] == SMAX[0]));
    chk("score_b", 32'(score_b), ms[1]);
    chk("high_b", 32'(high_b), mh[1]);
    chk("streak_b", 32'(streak_b), mk[1]);
    chk("bonus_b", 32'(bonus_b), int'(mb[1]));
    chk("new_high_b", 32'(new_high_b), int'(mn[1]));
    chk("sat_b", 32'(sat_b), int'(ms[1] == SMAX[1]));
  endtask

  task automatic step(input bit r, rs, en, w, m);
    @(negedge clk);
    reset = r; restart = rs; enable = en; whacked = w; missed = m;
    model(r, rs, en, w, m);
    @(posedge clk);
    #1 check_all();
  endtask

  typedef struct {
    bit r, rs, en, w, m;
    int sc, st, hi;
    bit b, nh;
  } vec_t;
  vec_t tv[24];
  int exp_hits[8] = '{1, 2, 3, 6, 7, 8, 9, 12};
  bit wr, mr;

  initial begin
    tv = '{
      '{1,0,0,0,0, 0,0,0, 0,0},
      '{0,0,1,1,0, 1,1,1, 0,1},
      '{0,0,1,0,0, 1,1,1, 0,0},
      '{0,0,1,1,0, 2,2,2, 0,1},
      '{0,0,1,1,0, 2,2,2, 0,0},
      '{0,0,1,1,0, 2,2,2, 0,0},
      '{0,0,1,0,0, 2,2,2, 0,0},
      '{0,0,1,1,0, 3,3,3, 0,1},
      '{0,0,1,0,0, 3,3,3, 0,0},
      '{0,0,1,1,0, 6,4,6, 1,1},
      '{0,0,1,0,0, 6,4,6, 0,0},
      '{0,0,1,0,1, 5,0,6, 0,0},
      '{0,0,1,0,0, 5,0,6, 0,0},
      '{0,0,1,1,1, 4,0,6, 0,0},
      '{0,0,1,0,0, 4,0,6, 0,0},
      '{0,0,0,1,0, 4,0,6, 0,0},
      '{0,0,1,1,0, 4,0,6, 0,0},
      '{0,0,1,0,0, 4,0,6, 0,0},
      '{0,0,1,1,0, 5,1,6, 0,0},
      '{0,0,1,0,0, 5,1,6, 0,0},
      '{0,1,1,1,0, 0,0,6, 0,0},
      '{0,0,1,1,0, 0,0,6, 0,0},
      '{0,0,1,0,1, 0,0,6, 0,0},
      '{0,0,1,0,0, 0,0,6, 0,0}
    };
    for (int i = 0; i < 24; i++) begin
      step(tv[i].r, tv[i].rs, tv[i].en, tv[i].w, tv[i].m);
      chk($sformatf("tv%0d_score", i), 32'(score_a), tv[i].sc);
      chk($sformatf("tv%0d_streak", i), 32'(streak_a), tv[i].st);
      chk($sformatf("tv%0d_high", i), 32'(high_a), tv[i].hi);
      chk($sformatf("tv%0d_bonus", i), 32'(bonus_a), int'(tv[i].b));
      chk($sformatf("tv%0d_new_high", i), 32'(new_high_a), int'(tv[i].nh));
    end
    // Eight hits from zero with high score 6 already held: equal score 6 must not pulse new_high
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 1, 0);
      chk($sformatf("hit%0d_score", i + 1), 32'(score_a), exp_hits[i]);
      chk($sformatf("hit%0d_bonus", i + 1), 32'(bonus_a), int'(i == 3 || i == 7));
      chk($sformatf("hit%0d_new_high", i + 1), 32'(new_high_a), int'(exp_hits[i] > 6));
      step(0, 0, 1, 0, 0);
    end
    // Drive the 4-bit instance into saturation
    for (int i = 0; i < 20 && ms[1] != 15; i++) begin
      step(0, 0, 1, 1, 0);
      step(0, 0, 1, 0, 0);
    end
    chk("sat_reach_score_b", 32'(score_b), 15);
    step(0, 0, 1, 1, 0);
    chk("sat_hold_score_b", 32'(score_b), 15);
    chk("sat_hold_flag_b", 32'(sat_b), 1);
    step(0, 1, 1, 0, 0);
    chk("restart_score_b", 32'(score_b), 0);
    chk("restart_high_b", 32'(high_b), 15);
    chk("restart_new_high_b", 32'(new_high_b), 0);
    step(1, 0, 1, 0, 0);
    chk("reset_high_b", 32'(high_b), 0);
    chk("reset_high_a", 32'(high_a), 0);
    wr = 0; mr = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) wr = ~wr;
      if ($urandom_range(0, 4) == 0) mr = ~mr;
      step($urandom_range(0, 399) == 0, $urandom_range(0, 59) == 0, $urandom_range(0, 7) != 0, wr, mr);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
